// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad credential-entry block.
// Provides key codes, the entry FSM state type, field widths and the
// credential payload carried from keypad entry to the ATM.
package atm_pkg;

    localparam int unsigned ACC_W      = 12;
    localparam int unsigned PIN_W      = 4;
    localparam int unsigned KEY_W      = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned ACC_DIGITS = 4;
    localparam int unsigned MAX_ACC    = 4095;

    localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hB;
    localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        PIN,
        WAIT,
        SESSION,
        LOCK
    } state_e;

    // Credential payload handed to the ATM.
    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [PIN_W-1:0] pin;
    } cred_t;

    // True for decimal digit key codes 0..9.
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= KEY_W'(9));
    endfunction

endpackage

// File: rtl/atm_digit_accumulator.sv
// Decimal digit accumulator: computes acc*10 + d as acc*8 + acc*2 + d.
// Ports:
//   acc_i      - current account field
//   digit_i    - incoming decimal digit (0..9)
//   next_acc_c - acc*10 + d, valid when ovf_c is low
//   ovf_c      - result would exceed MAX_ACC
module atm_digit_accumulator
    import atm_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [KEY_W-1:0] digit_i,
    output logic [ACC_W-1:0] next_acc_c,
    output logic             ovf_c
);

    localparam int unsigned      SUM_W    = ACC_W + 1;
    localparam logic [ACC_W-1:0] SAFE_MAX = ACC_W'(MAX_ACC / 10);

    logic [SUM_W-1:0] times8;
    logic [SUM_W-1:0] times2;
    logic [SUM_W-1:0] sum;

    // The 13-bit sum is exact whenever acc <= 409 (409*10+9 = 4099); larger
    // accumulators overflow regardless of the digit, so they are flagged directly.
    assign times8     = {acc_i[ACC_W-4:0], 3'b000};
    assign times2     = {acc_i, 1'b0};
    assign sum        = times8 + times2 + SUM_W'(digit_i);
    assign ovf_c      = (acc_i > SAFE_MAX) || (sum > SUM_W'(MAX_ACC));
    assign next_acc_c = sum[ACC_W-1:0];

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad credential-entry front end for the ATM FSM.
// Collects a 12-bit account number and a single PIN digit, pulses cred_valid,
// then tracks the ATM's authentication result with fail counting, lockout,
// cancel and inactivity timeout.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   key_valid, key_code     - one-cycle keypad strobe and code
//   auth_ok, auth_fail      - authentication result pulses from the ATM
//   acc_number, pin         - entered credential fields
//   cred_valid              - one-cycle pulse, credentials complete
//   exit                    - one-cycle pulse to the ATM exit input
//   locked                  - high during lockout
//   entry_error             - one-cycle pulse on a rejected key
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic             auth_ok,
    input  logic             auth_fail,
    output logic [ACC_W-1:0] acc_number,
    output logic [PIN_W-1:0] pin,
    output logic             cred_valid,
    output logic             exit,
    output logic             locked,
    output logic             entry_error
);

    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

    state_e              state_q, state_d;
    cred_t               cred_q, cred_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic                pin_have_q, pin_have_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                cred_valid_q, cred_valid_d;
    logic                exit_q, exit_d;
    logic                locked_q, locked_d;
    logic                entry_error_q, entry_error_d;

    logic                key_digit, key_clear, key_enter, key_cancel, key_any;
    logic [ACC_W-1:0]    acc_next_c;
    logic                acc_ovf_c;
    logic                timed, auth_evt, go_idle;

    // Key decode; codes D..F fall through as no key at all.
    assign key_digit  = key_valid && is_digit(key_code);
    assign key_clear  = key_valid && (key_code == KEY_CLEAR);
    assign key_enter  = key_valid && (key_code == KEY_ENTER);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);
    assign key_any    = key_digit || key_clear || key_enter || key_cancel;

    atm_digit_accumulator u_acc (
        .acc_i      (cred_q.acc),
        .digit_i    (key_code),
        .next_acc_c (acc_next_c),
        .ovf_c      (acc_ovf_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cred_q        <= '0;
            acc_cnt_q     <= '0;
            pin_have_q    <= 1'b0;
            fail_q        <= '0;
            tmr_q         <= '0;
            lock_q        <= '0;
            cred_valid_q  <= 1'b0;
            exit_q        <= 1'b0;
            locked_q      <= 1'b0;
            entry_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cred_q        <= cred_d;
            acc_cnt_q     <= acc_cnt_d;
            pin_have_q    <= pin_have_d;
            fail_q        <= fail_d;
            tmr_q         <= tmr_d;
            lock_q        <= lock_d;
            cred_valid_q  <= cred_valid_d;
            exit_q        <= exit_d;
            locked_q      <= locked_d;
            entry_error_q <= entry_error_d;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d       = state_q;
        cred_d        = cred_q;
        acc_cnt_d     = acc_cnt_q;
        pin_have_d    = pin_have_q;
        fail_d        = fail_q;
        tmr_d         = tmr_q;
        lock_d        = lock_q;
        cred_valid_d  = 1'b0;
        exit_d        = 1'b0;
        entry_error_d = 1'b0;
        go_idle       = 1'b0;

        timed    = (state_q == ACC) || (state_q == PIN) || (state_q == WAIT);
        auth_evt = (state_q == WAIT) && (auth_ok || auth_fail);

        // Inactivity timer; a key in the expiry cycle wins, and an auth
        // result in WAIT takes the block out of WAIT instead.
        if (timed) begin
            if (key_any) begin
                tmr_d = '0;
            end else if ((tmr_q == TMR_LAST) && !auth_evt) begin
                exit_d  = 1'b1;
                go_idle = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (key_digit) begin
                    cred_d.acc = ACC_W'(key_code);
                    acc_cnt_d  = CNT_W'(1);
                    state_d    = ACC;
                end
            end
            ACC: begin
                if (key_digit) begin
                    if ((acc_cnt_q == CNT_W'(ACC_DIGITS)) || acc_ovf_c) begin
                        entry_error_d = 1'b1;
                    end else begin
                        cred_d.acc = acc_next_c;
                        acc_cnt_d  = acc_cnt_q + CNT_W'(1);
                    end
                end else if (key_clear) begin
                    cred_d.acc = '0;
                    acc_cnt_d  = '0;
                end else if (key_enter) begin
                    state_d = PIN;
                end else if (key_cancel) begin
                    exit_d  = 1'b1;
                    go_idle = 1'b1;
                end
            end
            PIN: begin
                if (key_digit) begin
                    if (pin_have_q) begin
                        entry_error_d = 1'b1;
                    end else begin
                        cred_d.pin = key_code;
                        pin_have_d = 1'b1;
                    end
                end else if (key_enter) begin
                    if (!pin_have_q) begin
                        entry_error_d = 1'b1;
                    end else begin
                        cred_valid_d = 1'b1;
                        state_d      = WAIT;
                    end
                end else if (key_clear) begin
                    cred_d.pin = '0;
                    pin_have_d = 1'b0;
                end else if (key_cancel) begin
                    exit_d  = 1'b1;
                    go_idle = 1'b1;
                end
            end
            WAIT: begin
                // Cancel discards any simultaneous result; fail beats ok.
                if (key_cancel) begin
                    exit_d  = 1'b1;
                    go_idle = 1'b1;
                end else if (auth_fail) begin
                    fail_d = fail_q + FAIL_W'(1);
                    if ((fail_q + FAIL_W'(1)) == FAIL_MAX) begin
                        state_d = LOCK;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (auth_ok) begin
                    fail_d  = '0;
                    state_d = SESSION;
                end
            end
            SESSION: begin
                if (key_cancel) begin
                    exit_d  = 1'b1;
                    go_idle = 1'b1;
                end
            end
            LOCK: begin
                if (lock_q == LOCK_LAST) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_idle) begin
            state_d = IDLE;
        end

        // Fields are empty whenever the block rests in IDLE or LOCK.
        if ((state_d == IDLE) || (state_d == LOCK)) begin
            cred_d     = '0;
            acc_cnt_d  = '0;
            pin_have_d = 1'b0;
        end

        // Every state entry restarts the inactivity and lockout timers.
        if (state_d != state_q) begin
            tmr_d  = '0;
            lock_d = '0;
        end

        locked_d = (state_d == LOCK);
    end

    assign acc_number  = cred_q.acc;
    assign pin         = cred_q.pin;
    assign cred_valid  = cred_valid_q;
    assign exit        = exit_q;
    assign locked      = locked_q;
    assign entry_error = entry_error_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_atm_keypad_entry;
    import atm_pkg::*;

    localparam int unsigned T_MAX_FAILS = 3;
    localparam int unsigned T_LOCK      = 16;
    localparam int unsigned T_TIMEOUT   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             auth_ok;
    logic             auth_fail;
    logic [ACC_W-1:0] acc_number;
    logic [PIN_W-1:0] pin;
    logic             cred_valid;
    logic             exit;
    logic             locked;
    logic             entry_error;

    typedef enum int {EV_CRED = 0, EV_EXIT = 1, EV_ERR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       acc;
        int       pin_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    atm_keypad_entry #(
        .MAX_FAILS      (T_MAX_FAILS),
        .LOCK_CYCLES    (T_LOCK),
        .TIMEOUT_CYCLES (T_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .auth_ok     (auth_ok),
        .auth_fail   (auth_fail),
        .acc_number  (acc_number),
        .pin         (pin),
        .cred_valid  (cred_valid),
        .exit        (exit),
        .locked      (locked),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input int a, input int p);
        exp_t e;
        e.kind  = k;
        e.acc   = a;
        e.pin_v = p;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input ev_kind_e k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, expected none", int'(k));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            if (k == EV_CRED && e.kind == EV_CRED) begin
                check("cred_acc", int'(acc_number), e.acc);
                check("cred_pin", int'(pin), e.pin_v);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cred_valid)  mon_event(EV_CRED);
            if (exit)        mon_event(EV_EXIT);
            if (entry_error) mon_event(EV_ERR);
        end
    end

    task automatic press(input logic [KEY_W-1:0] c);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic pulse_auth(input logic ok, input logic fl);
        @(posedge clk); #1;
        auth_ok   = ok;
        auth_fail = fl;
        @(posedge clk); #1;
        auth_ok   = 1'b0;
        auth_fail = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Account 123, PIN 4, ending in WAIT with a cred_valid expected.
    task automatic entry_123_4();
        press(4'd1); press(4'd2); press(4'd3); press(KEY_ENTER); press(4'd4);
        push(EV_CRED, 123, 4);
        press(KEY_ENTER);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hi;
        bit  done;
        int  lat;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        auth_ok   = 1'b0;
        auth_fail = 1'b0;
        idle(2);
        check("rst_acc", int'(acc_number), 0);
        check("rst_pin", int'(pin), 0);
        check("rst_cred_valid", int'(cred_valid), 0);
        check("rst_exit", int'(exit), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_entry_error", int'(entry_error), 0);
        rst_n = 1'b1;
        idle(1);

        // Nominal entry, session, cancel.
        press(4'd2); press(4'd1); press(4'd7); press(4'd5);
        check("nom_acc_2175", int'(acc_number), 2175);
        press(KEY_ENTER); press(4'd1);
        push(EV_CRED, 2175, 1);
        press(KEY_ENTER);
        pulse_auth(1'b1, 1'b0);
        idle(3);
        check("session_acc_held", int'(acc_number), 2175);
        check("session_pin_held", int'(pin), 1);
        press(4'd9);
        check("session_key_ignored", int'(acc_number), 2175);
        push(EV_EXIT, 0, 0);
        press(KEY_CANCEL);
        check("cancel_acc_zero", int'(acc_number), 0);
        check("cancel_pin_zero", int'(pin), 0);

        // Overflow and digit-count limits.
        press(4'd4); press(4'd0); press(4'd9);
        push(EV_ERR, 0, 0);
        press(4'd6);
        check("ovf_acc_409", int'(acc_number), 409);
        press(KEY_CLEAR);
        check("clear_acc", int'(acc_number), 0);
        press(4'd4); press(4'd0); press(4'd9); press(4'd5);
        check("max_acc_4095", int'(acc_number), 4095);
        push(EV_ERR, 0, 0);
        press(4'd7);
        check("fifth_digit_acc", int'(acc_number), 4095);
        // PIN-field rejections: ENTER with no digit, second digit.
        press(KEY_ENTER);
        push(EV_ERR, 0, 0);
        press(KEY_ENTER);
        press(4'd3);
        push(EV_ERR, 0, 0);
        press(4'd8);
        check("pin_first_kept", int'(pin), 3);
        push(EV_EXIT, 0, 0);
        press(KEY_CANCEL);

        // Lockout after three failures.
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        check("fail1_not_locked", int'(locked), 0);
        check("fail1_fields_clear", int'(acc_number), 0);
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        check("fail2_not_locked", int'(locked), 0);
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        hi   = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (locked) begin
                hi++;
                key_valid = 1'b1;
                key_code  = (i % 2 == 1) ? KEY_CANCEL : 4'd3;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        check("lock_released", int'(done), 1);
        check("lock_cycles", hi, 16);
        // Key on the first cycle locked is seen low is accepted.
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("post_lock_key", int'(acc_number), 5);
        press(KEY_ENTER); press(4'd7);
        push(EV_CRED, 5, 7);
        press(KEY_ENTER);
        pulse_auth(1'b1, 1'b0);
        idle(1);
        check("post_lock_session", int'(acc_number), 5);
        push(EV_EXIT, 0, 0);
        press(KEY_CANCEL);

        // Inactivity timeout after one digit.
        press(4'd2);
        push(EV_EXIT, 0, 0);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (exit) lat = i;
        end
        check("timeout_latency", lat, 8);
        check("timeout_acc_clear", int'(acc_number), 0);
        check("timeout_not_locked", int'(locked), 0);

        // CANCEL + auth_ok + auth_fail together in WAIT.
        press(4'd3); press(KEY_ENTER); press(4'd4);
        push(EV_CRED, 3, 4);
        press(KEY_ENTER);
        push(EV_EXIT, 0, 0);
        @(posedge clk); #1;
        auth_ok   = 1'b1;
        auth_fail = 1'b1;
        key_valid = 1'b1;
        key_code  = KEY_CANCEL;
        @(posedge clk); #1;
        auth_ok   = 1'b0;
        auth_fail = 1'b0;
        key_valid = 1'b0;
        check("prec_acc_clear", int'(acc_number), 0);
        // Fail count must still be 0: two fails leave the keypad unlocked.
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        check("prec_fail_count_kept", int'(locked), 0);

        // Asynchronous reset in WAIT, with two fails on record.
        entry_123_4();
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_acc", int'(acc_number), 0);
        check("async_rst_pin", int'(pin), 0);
        check("async_rst_exit", int'(exit), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        entry_123_4();
        pulse_auth(1'b0, 1'b1);
        check("rst_cleared_fails", int'(locked), 0);
        entry_123_4();
        pulse_auth(1'b1, 1'b0);
        idle(1);
        check("fresh_session_acc", int'(acc_number), 123);
        push(EV_EXIT, 0, 0);
        press(KEY_CANCEL);

        idle(4);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Credential-entry front end sitting directly upstream of the ATM FSM. It turns single keypad strobes into the binary 12-bit account number and 4-bit PIN the ATM authenticates, and presents them with a one-cycle valid pulse. It then tracks the authentication result: failed attempts are counted and the keypad is locked out after too many. Cancel and inactivity timeout drive the ATM `exit` input.

## Interface
- `MAX_FAILS`, 3: consecutive auth failures that trigger lockout (≥1).
- `LOCK_CYCLES`, 1000: lockout duration in clk cycles (≥1).
- `TIMEOUT_CYCLES`, 5000: inactivity limit in clk cycles (≥2).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 4: 0–9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC CANCEL; 4'hD–4'hF are ignored.
- `auth_ok` in 1: pulse from the ATM meaning the credentials were accepted.
- `auth_fail` in 1: pulse from the ATM meaning the credentials were rejected.
- `acc_number` out 12: binary account number.
- `pin` out 4: binary PIN digit.
- `cred_valid` out 1: one-cycle pulse, credentials stable.
- `exit` out 1: one-cycle pulse to the ATM `exit` input.
- `locked` out 1: high throughout lockout.
- `entry_error` out 1: one-cycle pulse when a key is rejected.

## Operation
- **Reset values:** all outputs 0, state IDLE, fail count 0, timers 0.
- **IDLE**
  - A digit loads the account field with that digit (count = 1) → ACC.
  - All other keys are ignored.
- **ACC**
  - A digit computes acc×10+d.
  - The digit is rejected (entry_error, field unchanged) if the count is already 4 or the result exceeds 4095.
  - CLEAR zeroes the field and count, staying in ACC.
  - ENTER → PIN.
  - CANCEL → exit pulse, IDLE.
- **PIN**
  - The first digit is stored.
  - A second digit is rejected (entry_error).
  - ENTER with no digit is rejected (entry_error).
  - ENTER with a digit present → cred_valid pulse → WAIT.
  - CLEAR empties the PIN field.
  - CANCEL → exit, IDLE.
- **WAIT**
  - Keys other than CANCEL are ignored.
  - auth_ok → SESSION, fail count cleared.
  - auth_fail → fail count +1. If the count equals MAX_FAILS → LOCK; otherwise → IDLE with fields cleared.
- **SESSION**
  - acc_number and pin are held.
  - CANCEL → exit, IDLE, fields cleared.
  - All other keys are ignored; menu input is owned by the ATM.
- **LOCK**
  - locked=1 and all keys are ignored.
  - After LOCK_CYCLES cycles → IDLE, fail count 0, locked=0.
- **Inactivity timeout (ACC, PIN, WAIT only)**
  - The timer counts cycles without an accepted or rejected key.
  - It restarts at 0 on any key and on state entry.
  - Reaching TIMEOUT_CYCLES → exit pulse, IDLE, fields cleared.
  - Timeout does not increment the fail count.
- **Simultaneous events**
  - auth_ok with auth_fail: fail wins.
  - CANCEL with auth_ok or auth_fail in WAIT: cancel wins, the result is discarded, the fail count is unchanged.
  - A key in the same cycle as timeout expiry: the key wins and the timer restarts.
- auth_ok and auth_fail outside WAIT are ignored.

## Timing
- Inputs are sampled at the rising clk edge. All outputs are registered and change on the edge after the causing input: latency 1.
- cred_valid asserts the cycle after the ENTER that completes the PIN. acc_number and pin are stable from that cycle until the block leaves SESSION or returns to IDLE.
- exit and entry_error are exactly one cycle wide.
- Lockout:
  - locked rises the cycle after the final auth_fail.
  - It stays high for exactly LOCK_CYCLES cycles.
  - A key is accepted on the cycle locked is first observed low.
- Reset asserted mid-operation clears everything asynchronously. No exit pulse is generated for it.

## Structure
- **Package `atm_pkg`:**
  - key code constants: KEY_CLEAR, KEY_ENTER, KEY_CANCEL;
  - state enum: IDLE, ACC, PIN, WAIT, SESSION, LOCK;
  - widths: ACC_W=12, PIN_W=4, MAX_ACC=4095.
- **Sub-module `atm_digit_accumulator`:** decimal shift-multiply (acc×8 + acc×2 + d). It has a 13-bit intermediate and returns the next value plus an overflow flag. The top level owns the digit count and the timers.

## Test plan
- **Nominal entry:** keys 2,1,7,5,ENTER,1,ENTER → a single cred_valid with acc_number=2175 and pin=1. auth_ok → SESSION with outputs held. CANCEL → one exit pulse, outputs return to 0.
- **Overflow:** keys 4,0,9,6 → entry_error on 6, acc stays 409. CLEAR, then 4,0,9,5 → 4095 accepted. A fifth digit → entry_error.
- **Lockout (MAX_FAILS=3, LOCK_CYCLES=16):** three full entries, each answered by auth_fail → locked high for exactly 16 cycles, keys ignored meanwhile. The next entry succeeds normally.
- **Inactivity timeout (TIMEOUT_CYCLES=8):** after key 2, no input → exit pulse on the 8th idle cycle, state IDLE, fail count unchanged.
- **Precedence in WAIT:** auth_ok, auth_fail and CANCEL in the same cycle → exit pulse, IDLE, fail count unchanged.
- **Reset mid-WAIT:** rst_n low for 1 cycle → all outputs 0 immediately with no exit pulse. A fresh entry works normally afterwards.
